// File: rtl/psl_majority_voter.sv
// Histograms N_SAMPLES p-bit captures and reports the most frequent value (lowest index wins ties).
// Latency N_SAMPLES*CYCLES_PER_SAMPLE + 2**W + 1 cycles from accepted start; no backpressure, start ignored while busy.
module psl_majority_voter #(
  parameter int W                 = 4,
  parameter int N_SAMPLES         = 100,
  parameter int CYCLES_PER_SAMPLE = 12,
  parameter int REVERSE           = 1,
  parameter int EARLY_STOP        = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           abort,
  input  logic [W-1:0]                   psl_out,
  output logic                           busy,
  output logic [W-1:0]                   result,
  output logic [$clog2(N_SAMPLES+1)-1:0] confidence,
  output logic                           valid_res
);

  localparam int CW = $clog2(N_SAMPLES + 1);
  localparam int NB = 2 ** W;
  localparam int PW = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLES_PER_SAMPLE - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SMP_LAST   = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] ES_CNT     = CW'(EARLY_STOP);
  localparam logic [W:0]    SCAN_END   = (W + 1)'(NB);
  localparam logic [W:0]    SCAN_ONE   = (W + 1)'(1);

  typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   bins_q [NB];
  logic [PW-1:0]   phase_q;
  logic [CW-1:0]   smp_cnt_q;
  logic [W:0]      scan_cnt_q;
  logic [CW-1:0]   rd_q;
  logic [W-1:0]    rd_idx_q;
  logic [CW-1:0]   best_cnt_q, best_cnt_d;
  logic [W-1:0]    best_idx_q, best_idx_d;
  logic [W-1:0]    result_q;
  logic [CW-1:0]   conf_q;
  logic            valid_q;

  logic [W-1:0]    smp;
  logic [CW-1:0]   inc_cnt;
  logic            es_hit;

  always_comb begin
    smp = psl_out;
    if (REVERSE != 0) begin
      for (int i = 0; i < W; i++) smp[i] = psl_out[W-1-i];
    end
  end

  assign inc_cnt = bins_q[smp] + CNT_ONE;
  assign es_hit  = (EARLY_STOP != 0) && (inc_cnt == ES_CNT);

  // Bin reads are registered: rd_q holds bin scan_cnt_q-1 once scan_cnt_q is non-zero.
  always_comb begin
    best_cnt_d = best_cnt_q;
    best_idx_d = best_idx_q;
    if ((scan_cnt_q != '0) && (rd_q > best_cnt_q)) begin
      best_cnt_d = rd_q;
      best_idx_d = rd_idx_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      smp_cnt_q  <= '0;
      scan_cnt_q <= '0;
      rd_q       <= '0;
      rd_idx_q   <= '0;
      best_cnt_q <= '0;
      best_idx_q <= '0;
      result_q   <= '0;
      conf_q     <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < NB; i++) bins_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            for (int i = 0; i < NB; i++) bins_q[i] <= '0;
            phase_q   <= '0;
            smp_cnt_q <= '0;
            state_q   <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (phase_q == PHASE_LAST) begin
            phase_q      <= '0;
            bins_q[smp]  <= inc_cnt;
            smp_cnt_q    <= smp_cnt_q + CNT_ONE;
            if (es_hit) begin
              state_q  <= DONE;
              result_q <= smp;
              conf_q   <= ES_CNT;
              valid_q  <= 1'b1;
            end else if (smp_cnt_q == SMP_LAST) begin
              state_q    <= SCAN;
              scan_cnt_q <= '0;
              best_cnt_q <= '0;
              best_idx_q <= '0;
            end
          end else begin
            phase_q <= phase_q + PHASE_ONE;
          end
        end
        SCAN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            best_cnt_q <= best_cnt_d;
            best_idx_q <= best_idx_d;
            if (scan_cnt_q == SCAN_END) begin
              state_q  <= DONE;
              result_q <= best_idx_d;
              conf_q   <= best_cnt_d;
              valid_q  <= 1'b1;
            end else begin
              rd_q       <= bins_q[scan_cnt_q[W-1:0]];
              rd_idx_q   <= scan_cnt_q[W-1:0];
              scan_cnt_q <= scan_cnt_q + SCAN_ONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign result     = result_q;
  assign confidence = conf_q;
  assign valid_res  = valid_q;

endmodule

// File: tb/tb_psl_majority_voter.sv
// Directed bench for psl_majority_voter: three parameterisations sharing clock and reset.
module tb_psl_majority_voter;

  logic CLK = 1'b0;
  logic RST;

  logic       start_a, abort_a, busy_a, valid_a;
  logic [1:0] psl_a, res_a;
  logic [2:0] conf_a;

  logic       start_r, abort_r, busy_r, valid_r;
  logic [1:0] psl_r, res_r;
  logic [2:0] conf_r;

  logic       start_e, abort_e, busy_e, valid_e;
  logic [1:0] psl_e, res_e;
  logic [3:0] conf_e;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  psl_majority_voter #(.W(2), .N_SAMPLES(4), .CYCLES_PER_SAMPLE(3), .REVERSE(0), .EARLY_STOP(0)) u_a (
    .CLK(CLK), .RST(RST), .start(start_a), .abort(abort_a), .psl_out(psl_a),
    .busy(busy_a), .result(res_a), .confidence(conf_a), .valid_res(valid_a));

  psl_majority_voter #(.W(2), .N_SAMPLES(4), .CYCLES_PER_SAMPLE(3), .REVERSE(1), .EARLY_STOP(0)) u_r (
    .CLK(CLK), .RST(RST), .start(start_r), .abort(abort_r), .psl_out(psl_r),
    .busy(busy_r), .result(res_r), .confidence(conf_r), .valid_res(valid_r));

  psl_majority_voter #(.W(2), .N_SAMPLES(10), .CYCLES_PER_SAMPLE(3), .REVERSE(1), .EARLY_STOP(3)) u_e (
    .CLK(CLK), .RST(RST), .start(start_e), .abort(abort_e), .psl_out(psl_e),
    .busy(busy_e), .result(res_e), .confidence(conf_e), .valid_res(valid_e));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start_a = 1'b1; abort_a = 1'b0; psl_a = 2'b00;
    start_r = 1'b1; abort_r = 1'b0; psl_r = 2'b00;
    start_e = 1'b1; abort_e = 1'b0; psl_e = 2'b00;
    repeat (3) step();
    n_checks++; if (busy_a !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    n_checks++; if (valid_a !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    n_checks++; if (res_a !== 2'd0)     begin n_fail++; $display("FAIL reset_result got=%0d exp=0", res_a); end
    n_checks++; if (conf_a !== 3'd0)    begin n_fail++; $display("FAIL reset_conf got=%0d exp=0", conf_a); end
    n_checks++; if (busy_r !== 1'b0)    begin n_fail++; $display("FAIL reset_busy_r got=%b exp=0", busy_r); end
    n_checks++; if (conf_e !== 4'd0)    begin n_fail++; $display("FAIL reset_conf_e got=%0d exp=0", conf_e); end
    start_a = 1'b0; start_r = 1'b0; start_e = 1'b0;
    RST = 1'b0;
    step();
  endtask

  task automatic test_basic_vote();
    psl_a = 2'b10; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      n_checks++; if (valid_a !== (c == 17)) begin n_fail++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, valid_a, (c == 17)); end
      n_checks++; if (busy_a !== (c <= 17))  begin n_fail++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy_a, (c <= 17)); end
      if (c == 17) begin
        n_checks++; if (res_a !== 2'd2)  begin n_fail++; $display("FAIL basic_result got=%0d exp=2", res_a); end
        n_checks++; if (conf_a !== 3'd4) begin n_fail++; $display("FAIL basic_conf got=%0d exp=4", conf_a); end
      end
      step();
    end
    n_checks++; if (res_a !== 2'd2 || conf_a !== 3'd4) begin n_fail++; $display("FAIL basic_hold got=%0d/%0d exp=2/4", res_a, conf_a); end
  endtask

  task automatic test_tie_reverse();
    psl_r = 2'b01; start_r = 1'b1;
    step();
    start_r = 1'b0;
    for (int c = 0; c <= 19; c++) begin
      n_checks++; if (valid_r !== (c == 17)) begin n_fail++; $display("FAIL tie_valid c=%0d got=%b exp=%b", c, valid_r, (c == 17)); end
      if (c == 17) begin
        n_checks++; if (res_r !== 2'd1)  begin n_fail++; $display("FAIL tie_result got=%0d exp=1", res_r); end
        n_checks++; if (conf_r !== 3'd2) begin n_fail++; $display("FAIL tie_conf got=%0d exp=2", conf_r); end
      end
      psl_r = (c < 6) ? 2'b01 : 2'b10;
      step();
    end
    n_checks++; if (busy_r !== 1'b0) begin n_fail++; $display("FAIL tie_idle got=%b exp=0", busy_r); end
  endtask

  task automatic test_early_stop();
    psl_e = 2'b11; start_e = 1'b1;
    step();
    start_e = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      n_checks++; if (valid_e !== (c == 9)) begin n_fail++; $display("FAIL es_valid c=%0d got=%b exp=%b", c, valid_e, (c == 9)); end
      n_checks++; if (busy_e !== (c <= 9))  begin n_fail++; $display("FAIL es_busy c=%0d got=%b exp=%b", c, busy_e, (c <= 9)); end
      if (c == 9) begin
        n_checks++; if (res_e !== 2'd3)  begin n_fail++; $display("FAIL es_result got=%0d exp=3", res_e); end
        n_checks++; if (conf_e !== 4'd3) begin n_fail++; $display("FAIL es_conf got=%0d exp=3", conf_e); end
      end
      step();
    end
  endtask

  task automatic test_abort();
    psl_a = 2'b01; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c <= 25; c++) begin
      n_checks++; if (busy_a !== (c <= 6)) begin n_fail++; $display("FAIL abort_busy c=%0d got=%b exp=%b", c, busy_a, (c <= 6)); end
      n_checks++; if (valid_a !== 1'b0)    begin n_fail++; $display("FAIL abort_valid c=%0d got=%b exp=0", c, valid_a); end
      abort_a = (c == 6);
      step();
    end
    n_checks++; if (res_a !== 2'd2 || conf_a !== 3'd4) begin n_fail++; $display("FAIL abort_hold got=%0d/%0d exp=2/4", res_a, conf_a); end
    start_a = 1'b1; abort_a = 1'b1;
    step();
    start_a = 1'b0; abort_a = 1'b0;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle got=%b exp=0", busy_a); end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      n_checks++; if (valid_a !== (c == 17)) begin n_fail++; $display("FAIL restart_valid c=%0d got=%b exp=%b", c, valid_a, (c == 17)); end
      if (c == 17) begin
        n_checks++; if (res_a !== 2'd1 || conf_a !== 3'd4) begin n_fail++; $display("FAIL restart_out got=%0d/%0d exp=1/4", res_a, conf_a); end
      end
      step();
    end
  endtask

  task automatic test_start_busy_reset();
    psl_a = 2'b11; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c <= 19; c++) begin
      n_checks++; if (valid_a !== (c == 17)) begin n_fail++; $display("FAIL busy_start_valid c=%0d got=%b exp=%b", c, valid_a, (c == 17)); end
      n_checks++; if (busy_a !== (c <= 17))  begin n_fail++; $display("FAIL busy_start_busy c=%0d got=%b exp=%b", c, busy_a, (c <= 17)); end
      if (c == 17) begin
        n_checks++; if (res_a !== 2'd3 || conf_a !== 3'd4) begin n_fail++; $display("FAIL busy_start_out got=%0d/%0d exp=3/4", res_a, conf_a); end
      end
      start_a = (c == 4);
      step();
    end
    psl_a = 2'b00; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      RST = (c == 13);
      step();
    end
    n_checks++; if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
    n_checks++; if (res_a !== 2'd0)   begin n_fail++; $display("FAIL rst_result got=%0d exp=0", res_a); end
    n_checks++; if (conf_a !== 3'd0)  begin n_fail++; $display("FAIL rst_conf got=%0d exp=0", conf_a); end
    RST = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      n_checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_quiet c=%0d got=%b/%b exp=0/0", c, valid_a, busy_a); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    psl_a = 2'b00; start_a = 1'b1;
    step();
    for (int c = 0; c <= 60; c++) begin
      n_checks++;
      if (valid_a !== (c == 17 || c == 36 || c == 55)) begin
        n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, valid_a, (c == 17 || c == 36 || c == 55));
      end
      if (c == 55) begin
        n_checks++; if (res_a !== 2'd0 || conf_a !== 3'd4) begin n_fail++; $display("FAIL b2b_out got=%0d/%0d exp=0/4", res_a, conf_a); end
      end
      if (c == 56) start_a = 1'b0;
      step();
    end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", busy_a); end
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_tie_reverse();
    test_early_stop();
    test_abort();
    test_start_busy_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psl_majority_voter.md
PSL_MAJORITY_VOTER -- requirements
Module: psl_majority_voter

Interface
REQ-001 The block SHALL have parameter W, default 4: result width in bits; the block keeps 2**W histogram bins.
REQ-002 The block SHALL have parameter N_SAMPLES, default 100: number of samples per request, minimum 1.
REQ-003 The block SHALL have parameter CYCLES_PER_SAMPLE, default 12: clock cycles per p-bit sweep, minimum 1.
REQ-004 The block SHALL have parameter REVERSE, default 1: when 1, psl_out bit i maps to sample bit W-1-i; when 0, no mapping.
REQ-005 The block SHALL have parameter EARLY_STOP, default 0: bin count that ends sampling early; 0 disables it; legal range 0..N_SAMPLES.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all logic on the rising edge.
REQ-007 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port start, input, 1 bit: request pulse; sampled only in IDLE.
REQ-009 The block SHALL have port abort, input, 1 bit: cancels an in-flight request.
REQ-010 The block SHALL have port psl_out, input, W bits: p-bit output states.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 The block SHALL have port result, output, W bits: winning bin index.
REQ-013 The block SHALL have port confidence, output, clog2(N_SAMPLES+1) bits: winning bin count.
REQ-014 The block SHALL have port valid_res, output, 1 bit: one-cycle pulse marking new result and confidence values.

Function
REQ-015 The FSM SHALL have states IDLE, SAMPLE, SCAN and DONE.
REQ-016 In IDLE, start=1 with abort=0 SHALL clear all bins, the phase counter and the sample counter, and enter SAMPLE on the next edge.
REQ-017 In SAMPLE, the phase counter SHALL count 0..CYCLES_PER_SAMPLE-1 and wrap to 0.
REQ-018 When phase==CYCLES_PER_SAMPLE-1 in SAMPLE, the mapped psl_out SHALL be captured and its bin incremented by 1.
REQ-019 Bin counts SHALL be clog2(N_SAMPLES+1) bits wide and SHALL never saturate or wrap, since total increments are at most N_SAMPLES.
REQ-020 After the N_SAMPLES-th capture, the FSM SHALL enter SCAN.
REQ-021 The SAMPLE phase SHALL last exactly N_SAMPLES*CYCLES_PER_SAMPLE cycles.
REQ-022 SCAN SHALL visit one bin per cycle, index 0..2**W-1, with best_count starting at 0 and best_idx starting at 0.
REQ-023 In SCAN, the visited bin SHALL replace the best value only when its count is strictly greater than best_count, so ties resolve to the lowest index.
REQ-024 After visiting index 2**W-1, the FSM SHALL enter DONE.
REQ-025 In DONE, result SHALL take best_idx, confidence SHALL take best_count, and valid_res SHALL be 1, all for exactly one cycle; the FSM SHALL then enter IDLE.
REQ-026 result and confidence SHALL hold their values until the next DONE.
REQ-027 Latency: if start is accepted at edge t, valid_res SHALL be high in the cycle after edge t + N_SAMPLES*CYCLES_PER_SAMPLE + 2**W + 1.
REQ-028 Early stop: when EARLY_STOP>0 and an increment makes a bin equal EARLY_STOP, the FSM SHALL skip SCAN and go directly to DONE with result=that bin and confidence=EARLY_STOP.
REQ-029 start SHALL be ignored in SAMPLE, SCAN and DONE; it is neither queued nor counted.
REQ-030 abort=1 in SAMPLE or SCAN SHALL return the FSM to IDLE on the next edge with no valid_res pulse, and result and confidence unchanged.
REQ-031 abort SHALL have no effect in DONE; the pulse still occurs.
REQ-032 abort=1 together with start=1 in IDLE SHALL keep the FSM in IDLE; abort wins.
REQ-033 A capture and an early-stop match in the same cycle as the N_SAMPLES-th capture SHALL take the early-stop path.

Reset
REQ-034 RST=1 at a rising edge SHALL force state IDLE, busy=0, valid_res=0, result=0, confidence=0, and clear all bins and counters.
REQ-035 RST SHALL override start and abort.
REQ-036 RST asserted mid-operation SHALL discard the request; no valid_res pulse SHALL follow.

Verification
REQ-037 Basic vote (W=2, N_SAMPLES=4, CYCLES_PER_SAMPLE=3, REVERSE=0, EARLY_STOP=0): start at cycle 0 with psl_out constant 2'b10 -> valid_res high at cycle 18 only, result=2, confidence=4, busy low from cycle 19.
REQ-038 Tie and reversal (same parameters, REVERSE=1): captures 01,01,10,10 -> both bins hold 2; result=1 (mapped 10 has index 1), confidence=2.
REQ-039 Early stop (N_SAMPLES=10, EARLY_STOP=3, psl_out constant 3) -> valid_res follows the third capture by one cycle, with no SCAN cycles; result=3, confidence=3.
REQ-040 Abort (first parameters): abort at cycle 7 -> busy=0 from cycle 8, no valid_res, result and confidence keep their previous values; a new start is then accepted normally.
REQ-041 Start while busy, then reset mid-scan: a second start at cycle 5 is ignored and the latency stays 18; then RST at cycle 14 -> all outputs 0, no pulse.
REQ-042 Back-to-back: start is held high continuously -> a new request begins in the cycle after each DONE, and valid_res pulses every 19 cycles.
